// File: rtl/f_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : f_wb_scheduler
// Purpose  : Round-robin arbiter for the FP register-file write port, with a
//            one-entry registered write stage and a per-register busy
//            scoreboard for RAW/WAW hazard detection.
//            Optional macro F_WB_BYPASS_EN enables forwarding from f_w_data.
// Revision : 1.0 - initial release
// ============================================================================
module f_wb_scheduler #(
    parameter int NREQ  = 3,
    parameter int WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_rd,
    input  logic [4:0]            chk_rs1,
    input  logic [4:0]            chk_rs2,
    input  logic                  chk_rs1_en,
    input  logic                  chk_rs2_en,
    output logic                  hazard,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [5*NREQ-1:0]     req_rd,
    input  logic [WIDTH*NREQ-1:0] req_data,
    input  logic [5*NREQ-1:0]     req_flags,
    output logic [NREQ-1:0]       req_ready,
    output logic                  f_wen,
    output logic [4:0]            f_rd,
    output logic [WIDTH-1:0]      f_w_data,
    output logic                  f_NV,
    output logic                  f_DZ,
    output logic                  f_OF,
    output logic                  f_UF,
    output logic                  f_NX,
    output logic                  byp_rs1,
    output logic                  byp_rs2
);

    localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [c_PW-1:0]  r_ptr;
    logic [c_PW-1:0]  w_win;
    logic [c_PW-1:0]  w_ptr_nxt;
    logic [NREQ-1:0]  w_grant;
    logic             w_found;
    logic             w_xfer;
    logic [4:0]       w_sel_rd;
    logic [WIDTH-1:0] w_sel_data;
    logic [4:0]       w_sel_flags;

    logic             r_wen;
    logic [4:0]       r_rd;
    logic [WIDTH-1:0] r_data;
    logic [4:0]       r_flags;
    logic [31:0]      r_busy;
    logic [31:0]      w_busy_nxt;
    logic             w_set;
    logic             w_byp1;
    logic             w_byp2;
    logic             w_waw_ok;

    // Two passes: indices at/above the pointer first, then the wrapped part.
    always_comb begin
        w_grant = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (i >= int'(r_ptr))) begin
                w_found    = 1'b1;
                w_grant[i] = 1'b1;
                w_win      = c_PW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (i < int'(r_ptr))) begin
                w_found    = 1'b1;
                w_grant[i] = 1'b1;
                w_win      = c_PW'(i);
            end
        end
    end

    always_comb begin
        w_sel_rd    = '0;
        w_sel_data  = '0;
        w_sel_flags = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_rd    = req_rd[5*i +: 5];
                w_sel_data  = req_data[WIDTH*i +: WIDTH];
                w_sel_flags = req_flags[5*i +: 5];
            end
        end
    end

    assign w_xfer    = w_found & ~RST;
    assign req_ready = RST ? '0 : w_grant;
    assign w_ptr_nxt = (w_win == c_PW'(NREQ - 1)) ? '0 : w_win + c_PW'(1);

`ifdef F_WB_BYPASS_EN
    // A source being written this cycle is forwarded instead of stalling.
    assign w_byp1   = chk_rs1_en & r_busy[chk_rs1] & r_wen & (chk_rs1 == r_rd);
    assign w_byp2   = chk_rs2_en & r_busy[chk_rs2] & r_wen & (chk_rs2 == r_rd);
    assign w_waw_ok = r_wen & (issue_rd == r_rd);
`else
    assign w_byp1   = 1'b0;
    assign w_byp2   = 1'b0;
    assign w_waw_ok = 1'b0;
`endif

    assign hazard  = (chk_rs1_en & r_busy[chk_rs1] & ~w_byp1)
                   | (chk_rs2_en & r_busy[chk_rs2] & ~w_byp2)
                   | (issue_valid & r_busy[issue_rd] & ~w_waw_ok);
    assign byp_rs1 = w_byp1;
    assign byp_rs2 = w_byp2;
    assign w_set   = issue_valid & ~hazard;

    // Clear first so a same-register set in the same cycle wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wen) begin
            w_busy_nxt[r_rd] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr   <= '0;
            r_wen   <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
            r_flags <= '0;
            r_busy  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_xfer) begin
                r_ptr   <= w_ptr_nxt;
                r_wen   <= 1'b1;
                r_rd    <= w_sel_rd;
                r_data  <= w_sel_data;
                r_flags <= w_sel_flags;
            end else begin
                r_wen   <= 1'b0;
                r_flags <= '0;
            end
        end
    end

    assign f_wen    = r_wen;
    assign f_rd     = r_rd;
    assign f_w_data = r_data;
    assign f_NV     = r_flags[4];
    assign f_DZ     = r_flags[3];
    assign f_OF     = r_flags[2];
    assign f_UF     = r_flags[1];
    assign f_NX     = r_flags[0];

endmodule
`default_nettype wire

// File: tb/tb_f_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_f_wb_scheduler
// Purpose  : Directed self-checking bench for f_wb_scheduler (NREQ=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_f_wb_scheduler;

    localparam int NREQ  = 3;
    localparam int WIDTH = 32;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic                  issue_valid = 1'b0;
    logic [4:0]            issue_rd = '0;
    logic [4:0]            chk_rs1 = '0;
    logic [4:0]            chk_rs2 = '0;
    logic                  chk_rs1_en = 1'b0;
    logic                  chk_rs2_en = 1'b0;
    logic                  hazard;
    logic [NREQ-1:0]       req_valid = '0;
    logic [5*NREQ-1:0]     req_rd = '0;
    logic [WIDTH*NREQ-1:0] req_data = '0;
    logic [5*NREQ-1:0]     req_flags = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  f_wen;
    logic [4:0]            f_rd;
    logic [WIDTH-1:0]      f_w_data;
    logic                  f_NV, f_DZ, f_OF, f_UF, f_NX;
    logic                  byp_rs1, byp_rs2;

    int checks = 0;
    int errors = 0;

    f_wb_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
        .chk_rs1_en(chk_rs1_en), .chk_rs2_en(chk_rs2_en),
        .hazard(hazard),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
        .req_flags(req_flags), .req_ready(req_ready),
        .f_wen(f_wen), .f_rd(f_rd), .f_w_data(f_w_data),
        .f_NV(f_NV), .f_DZ(f_DZ), .f_OF(f_OF), .f_UF(f_UF), .f_NX(f_NX),
        .byp_rs1(byp_rs1), .byp_rs2(byp_rs2)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_src(input int i, input logic [4:0] rd,
                           input logic [WIDTH-1:0] data, input logic [4:0] fl);
        req_rd[5*i +: 5]        = rd;
        req_data[WIDTH*i +: WIDTH] = data;
        req_flags[5*i +: 5]     = fl;
    endtask

    task automatic test_reset();
        tick();
        tick();
        RST = 1'b0;
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        set_src(1, 5'd12, 32'hDEADBEEF, 5'b10000);
        req_valid   = 3'b010;
        tick();
        issue_valid = 1'b0;
        req_valid   = 3'b000;
        chk_rs1 = 5'd5; chk_rs1_en = 1'b1;
        #1;
        checks++; if (f_wen !== 1'b1 || hazard !== 1'b1) begin errors++;
            $display("FAIL pre_reset_activity f_wen=%b hazard=%b exp 1 1", f_wen, hazard); end
        RST = 1'b1;
        #1;
        checks++; if (f_wen !== 1'b0 || f_rd !== 5'd0 || f_w_data !== 32'd0) begin errors++;
            $display("FAIL reset_write_stage wen=%b rd=%0d data=%h exp 0 0 0", f_wen, f_rd, f_w_data); end
        checks++; if ({f_NV, f_DZ, f_OF, f_UF, f_NX} !== 5'b0) begin errors++;
            $display("FAIL reset_flags got %b exp 00000", {f_NV, f_DZ, f_OF, f_UF, f_NX}); end
        checks++; if (hazard !== 1'b0) begin errors++;
            $display("FAIL reset_busy_clear hazard=%b exp 0", hazard); end
        checks++; if (req_ready !== 3'b000) begin errors++;
            $display("FAIL reset_ready got %b exp 000", req_ready); end
        #1;
        RST = 1'b0;
        chk_rs1_en = 1'b0;
        req_valid = 3'b111;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++;
            $display("FAIL reset_ptr_zero ready=%b exp 001", req_ready); end
        req_valid = 3'b000;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_rdy;
        int s;
        for (int i = 0; i < NREQ; i++) set_src(i, 5'(i + 1), 32'h100 + i, 5'b0);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_rdy = 3'b001 << (c % 3);
            checks++; if (req_ready !== exp_rdy) begin errors++;
                $display("FAIL rr_grant cycle %0d ready=%b exp %b", c, req_ready, exp_rdy); end
            if (c > 0) begin
                s = (c - 1) % 3;
                checks++; if (f_wen !== 1'b1 || f_rd !== 5'(s + 1) || f_w_data !== 32'h100 + s) begin errors++;
                    $display("FAIL rr_write cycle %0d wen=%b rd=%0d data=%h exp 1 %0d %h",
                             c, f_wen, f_rd, f_w_data, s + 1, 32'h100 + s); end
            end else begin
                checks++; if (f_wen !== 1'b0) begin errors++;
                    $display("FAIL rr_first_idle wen=%b exp 0", f_wen); end
            end
            tick();
        end
        req_valid = 3'b000;
        checks++; if (f_wen !== 1'b1 || f_rd !== 5'd3) begin errors++;
            $display("FAIL rr_last_write wen=%b rd=%0d exp 1 3", f_wen, f_rd); end
        tick();
        checks++; if (f_wen !== 1'b0 || f_rd !== 5'd3 || f_w_data !== 32'h102) begin errors++;
            $display("FAIL rr_hold wen=%b rd=%0d data=%h exp 0 3 102", f_wen, f_rd, f_w_data); end
    endtask

    task automatic test_fairness();
        req_valid = 3'b100;
        #1;
        checks++; if (req_ready !== 3'b100) begin errors++;
            $display("FAIL fair_only2 ready=%b exp 100", req_ready); end
        tick();
        req_valid = 3'b011;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++;
            $display("FAIL fair_src0_first ready=%b exp 001", req_ready); end
        tick();
        req_valid = 3'b010;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++;
            $display("FAIL fair_src1_next ready=%b exp 010", req_ready); end
        tick();
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_raw();
        logic exp_hz;
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        checks++; if (hazard !== 1'b0) begin errors++;
            $display("FAIL raw_issue_free hazard=%b exp 0", hazard); end
        tick();
        issue_valid = 1'b0;
        chk_rs1 = 5'd7; chk_rs1_en = 1'b1;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++;
            $display("FAIL raw_busy_c1 hazard=%b exp 1", hazard); end
        tick();
        set_src(1, 5'd7, 32'h3F800000, 5'b00001);
        req_valid = 3'b010;
        #1;
        checks++; if (hazard !== 1'b1 || req_ready !== 3'b010) begin errors++;
            $display("FAIL raw_busy_c2 hazard=%b ready=%b exp 1 010", hazard, req_ready); end
        tick();
        req_valid = 3'b000;
        #1;
`ifdef F_WB_BYPASS_EN
        exp_hz = 1'b0;
        checks++; if (byp_rs1 !== 1'b1) begin errors++;
            $display("FAIL raw_byp byp_rs1=%b exp 1", byp_rs1); end
`else
        exp_hz = 1'b1;
        checks++; if (byp_rs1 !== 1'b0 || byp_rs2 !== 1'b0) begin errors++;
            $display("FAIL raw_byp_off byp=%b%b exp 00", byp_rs1, byp_rs2); end
`endif
        checks++; if (hazard !== exp_hz) begin errors++;
            $display("FAIL raw_wen_cycle hazard=%b exp %b", hazard, exp_hz); end
        checks++; if (f_wen !== 1'b1 || f_rd !== 5'd7 || f_w_data !== 32'h3F800000) begin errors++;
            $display("FAIL raw_write wen=%b rd=%0d data=%h exp 1 7 3f800000", f_wen, f_rd, f_w_data); end
        checks++; if ({f_NV, f_DZ, f_OF, f_UF, f_NX} !== 5'b00001) begin errors++;
            $display("FAIL raw_flags got %b exp 00001", {f_NV, f_DZ, f_OF, f_UF, f_NX}); end
        tick();
        checks++; if (hazard !== 1'b0 || f_NX !== 1'b0 || byp_rs1 !== 1'b0) begin errors++;
            $display("FAIL raw_cleared hazard=%b nx=%b byp=%b exp 0 0 0", hazard, f_NX, byp_rs1); end
        chk_rs1_en = 1'b0;
    endtask

    task automatic test_collision();
        logic exp_hz, exp_busy;
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        set_src(0, 5'd9, 32'h55, 5'b0);
        req_valid = 3'b001;
        tick();
        req_valid = 3'b000;
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
`ifdef F_WB_BYPASS_EN
        exp_hz = 1'b0; exp_busy = 1'b1;
`else
        exp_hz = 1'b1; exp_busy = 1'b0;
`endif
        checks++; if (f_wen !== 1'b1 || f_rd !== 5'd9 || hazard !== exp_hz) begin errors++;
            $display("FAIL coll_hazard wen=%b rd=%0d hazard=%b exp 1 9 %b", f_wen, f_rd, hazard, exp_hz); end
        tick();
        issue_valid = 1'b0;
        chk_rs1 = 5'd9; chk_rs1_en = 1'b1;
        #1;
        checks++; if (hazard !== exp_busy) begin errors++;
            $display("FAIL coll_busy9 hazard=%b exp %b", hazard, exp_busy); end
        chk_rs1_en = 1'b0;
    endtask

    task automatic test_waw();
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        #1;
        checks++; if (hazard !== 1'b1) begin errors++;
            $display("FAIL waw_hazard hazard=%b exp 1", hazard); end
        tick();
        issue_valid = 1'b0;
        chk_rs1 = 5'd3; chk_rs1_en = 1'b1;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++;
            $display("FAIL waw_busy_kept hazard=%b exp 1", hazard); end
        chk_rs1 = 5'd4;
        #1;
        checks++; if (hazard !== 1'b0) begin errors++;
            $display("FAIL waw_other_reg hazard=%b exp 0", hazard); end
        chk_rs1_en = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        issue_valid = 1'b0;
        chk_rs2 = 5'd0; chk_rs2_en = 1'b1;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++;
            $display("FAIL f0_tracked hazard=%b exp 1", hazard); end
        chk_rs2_en = 1'b0;
        #1;
        checks++; if (hazard !== 1'b0) begin errors++;
            $display("FAIL rs2_en_gate hazard=%b exp 0", hazard); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fairness();
        test_raw();
        test_collision();
        test_waw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/f_wb_scheduler.md
Name: f_wb_scheduler

Overview:
- Schedules the single write port of the FP register file between NREQ FPU result sources, e.g. add/sub, mul and iterative div/sqrt.
- Round-robin arbitration over valid/ready requests.
- One-entry registered write stage driving f_wen/f_rd/f_w_data and the NV/DZ/OF/UF/NX accrued-flag strobes.
- Per-register pending scoreboard; the control unit uses its hazard output to stall issue on RAW/WAW.

Parameters:
NREQ, 3, number of result sources competing for the write port (2..8)
WIDTH, 32, FP data width (word_t)

Ports:
CLK  input  1  clock
RST  input  1  asynchronous active-high reset
issue_valid  input  1  CU issues an FP op that will write issue_rd
issue_rd  input  5  destination of issued op
chk_rs1  input  5  source 1 of op being considered for issue
chk_rs2  input  5  source 2 of op being considered for issue
chk_rs1_en  input  1  chk_rs1 is read by that op
chk_rs2_en  input  1  chk_rs2 is read by that op
hazard  output  1  combinational; CU must not issue this cycle
req_valid  input  NREQ  source i holds a result
req_rd  input  5*NREQ  destination per source, slice i = [5i+4:5i]
req_data  input  WIDTH*NREQ  result per source
req_flags  input  5*NREQ  {NV,DZ,OF,UF,NX} per source
req_ready  output  NREQ  one-hot grant; transfer when valid&ready
f_wen  output  1  FP RF write enable
f_rd  output  5  FP RF write address
f_w_data  output  WIDTH  FP RF write data
f_NV, f_DZ, f_OF, f_UF, f_NX  output  1 each  flag strobes, valid only with f_wen
byp_rs1, byp_rs2  output  1 each  source to be taken from f_w_data (see optional feature)

Behaviour:
- Reset (async, RST=1): f_wen=0, f_rd=0, f_w_data=0, all flags=0, req_ready=0, busy[31:0]=0, rr pointer=0. Reset mid-transfer drops any granted-but-unwritten result; sources must also be reset.
- Arbitration, combinational each cycle:
  - Search req_valid starting at index ptr, wrapping NREQ-1 -> 0; first valid wins.
  - req_ready is one-hot on the winner, all zero when no req_valid.
  - Write stage is always free (one-cycle drain), so no back-pressure beyond losing arbitration.
  - Sources must hold valid/rd/data/flags stable until ready.
- Pointer: on a transfer from index w, ptr <= (w+1) mod NREQ; unchanged otherwise. A source that loses waits at most NREQ-1 cycles.
- Write stage, latency 1:
  - Transfer at edge t drives f_wen=1 plus the winner's rd/data/flags during cycle t+1.
  - With no transfer: f_wen=0 and flags=0; f_rd/f_w_data hold their last values.
- Scoreboard, busy bit per f0..f31 (f0 is a real register, tracked):
  - Set: issue_valid & !hazard sets busy[issue_rd].
  - Clear: a write stage cycle with f_wen=1 clears busy[f_rd] at the end of that cycle.
  - Set and clear of the same register in the same cycle: set wins.
  - issue_valid while hazard=1 is ignored, no state change.
- hazard = (chk_rs1_en & busy[chk_rs1]) | (chk_rs2_en & busy[chk_rs2]) | (issue_valid & busy[issue_rd]). This covers RAW plus WAW.
- A req_rd that is not busy is still written; the scheduler does not police sources.
- All NREQ valid every cycle: grants rotate 0,1,2,0,... with one write per cycle.

Optional Feature:
- Macro: F_WB_BYPASS_EN.
- Defined:
  - A busy source register equal to f_rd while f_wen=1 does not raise hazard; its RAW term is masked.
  - byp_rs1/byp_rs2 assert for that match so the CU forwards f_w_data.
  - A WAW check against issue_rd still hazards when busy, unless issue_rd==f_rd with f_wen=1, which is allowed because set wins.
- Undefined: byp_rs1=byp_rs2=0 constant; hazard exactly as in Behaviour.

Test Plan:
- Reset state: RST pulse mid-activity with busy[5]=1 and f_wen=1 -> next cycle all outputs 0, busy all 0, ptr 0; chk_rs1=5 with en gives hazard=0.
- Round-robin: req_valid=3'b111 held 6 cycles -> req_ready sequence 001,010,100,001,010,100; f_wen=1 from cycle 2 with f_rd tracking each source's rd, 1 cycle behind.
- Fairness after idle: only src2 valid, granted; then 3'b011 -> src0 granted first (ptr=0), then src1.
- Scoreboard RAW: issue rd=7, src1 returns rd=7 data=0x3F800000 flags=5'b00001 three cycles later -> hazard on chk_rs1=7 until the f_wen cycle; f_NX=1 only that cycle; hazard=0 the following cycle (1 cycle earlier with F_WB_BYPASS_EN, byp_rs1=1).
- Set/clear collision: f_wen=1, f_rd=9 while issue_valid, issue_rd=9 -> without the macro hazard=1 and issue ignored, busy[9] clears; with the macro busy[9] stays 1.
- WAW: busy[3]=1, issue_valid with issue_rd=3 -> hazard=1, busy unchanged; f0 issue then chk_rs2=0 -> hazard=1.
